// File: rtl/axi_mem_pkg.sv
// Shared definitions for the DRAM-model AXI blocks: response codes, engine states
// and the page extraction helper.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_FETCH     = 2'd2,
    ST_BEAT      = 2'd3
  } eng_state_e;

  function automatic logic [31:0] page_of(input logic [31:0] addr, input int unsigned off_w);
    return addr >> off_w;
  endfunction

endpackage

// File: rtl/axi_req_fifo.sv
// Generic synchronous FIFO with full/empty flags; head word is visible combinationally
// once written, never in the same cycle as the push.
module axi_req_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, rptr_q;
  logic                do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_rd_latency_responder.sv
// AXI4 read responder for the DRAM model: queues AR requests and returns R beats after
// a hot/cold page latency, fetching each beat from a 1-cycle synchronous memory port.
module axi_rd_latency_responder
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH               = 16,
  parameter int DATA_WIDTH               = 32,
  parameter int ID_WIDTH                 = 4,
  parameter int PAGE_OFFSET_WIDTH        = 6,
  parameter int SHORT_DELAY_CYCLES_WIDTH = 2,
  parameter int LONG_DELAY_CYCLES_WIDTH  = 4,
  parameter int FIFO_DEPTH_LOG2          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW      = LONG_DELAY_CYCLES_WIDTH;
  localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + 8;
  localparam logic [CW-1:0] LONG_INIT  = '1;
  localparam logic [CW-1:0] SHORT_INIT = CW'((1 << SHORT_DELAY_CYCLES_WIDTH) - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  eng_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           open_page_q;
  logic [ID_WIDTH-1:0]   id_q, rid_q;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr_q;
  logic [7:0]            len_q, beat_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q, rlast_q, mem_en_q, beat_first_q, ready_q;

  logic                  fifo_full, fifo_empty, fifo_pop, ar_push;
  logic [ENTRY_W-1:0]    head;
  logic [ID_WIDTH-1:0]   head_id;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [7:0]            head_len;
  logic [31:0]           head_page;

  assign s_axi_arready = ready_q & ~fifo_full;
  assign ar_push       = s_axi_arvalid & s_axi_arready;
  assign fifo_pop      = (state_q == ST_IDLE) & ~fifo_empty;
  assign {head_id, head_addr, head_len} = head;
  assign head_page     = page_of(32'(head_addr), PAGE_OFFSET_WIDTH);

  axi_req_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (ar_push),
    .data_i  ({s_axi_arid, s_axi_araddr, s_axi_arlen}),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Memory data arrives during the first BEAT cycle; it is forwarded then and held
  // in rdata_q for any backpressured cycles that follow.
  assign s_axi_rdata  = beat_first_q ? mem_rdata : rdata_q;
  assign s_axi_rid    = rid_q;
  assign s_axi_rresp  = RESP_OKAY;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      open_page_q  <= '0;
      id_q         <= '0;
      rid_q        <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      beat_first_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            id_q        <= head_id;
            addr_q      <= head_addr;
            len_q       <= head_len;
            beat_cnt_q  <= '0;
            cnt_q       <= (head_page == open_page_q) ? SHORT_INIT : LONG_INIT;
            open_page_q <= head_page;
            state_q     <= ST_COUNTDOWN;
          end
        end
        ST_COUNTDOWN: begin
          if (cnt_q == '0) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= addr_q;
            state_q    <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_FETCH: begin
          mem_en_q     <= 1'b0;
          rvalid_q     <= 1'b1;
          rid_q        <= id_q;
          rlast_q      <= (beat_cnt_q == len_q);
          beat_first_q <= 1'b1;
          state_q      <= ST_BEAT;
        end
        ST_BEAT: begin
          beat_first_q <= 1'b0;
          if (beat_first_q) rdata_q <= mem_rdata;
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q     <= addr_q + BEAT_STEP;
              mem_addr_q <= addr_q + BEAT_STEP;
              mem_en_q   <= 1'b1;
              beat_cnt_q <= beat_cnt_q + 8'd1;
              state_q    <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_latency_responder.sv
// Randomized bench for axi_rd_latency_responder against a transaction-level timing model.
module tb_axi_rd_latency_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  axi_rd_latency_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] memfn(input logic [15:0] a);
    return {a, a ^ 16'hA5C3};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle synchronous memory
  always @(posedge clk) if (mem_en) mem_rdata <= memfn(mem_addr);

  typedef struct {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    int          hs;
  } ar_t;

  ar_t         q[$];
  bit          started = 0;
  int          start_c, exp_valid, beat, occ;
  int          engine_free = 0;
  int          rel_cyc = 1 << 30;
  logic [15:0] baddr;
  logic [9:0]  open_pg = '0, pg;
  bit          exp_rv;
  int          rmode = 0;
  int          nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = ($urandom_range(0, 3) != 0);
        default: rready = 1'b0;
      endcase
    end
  end

  // Reference model: each burst starts when it is visible and the engine is free,
  // first beat after page latency, each later beat two cycles after the last handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cyc > rel_cyc) begin
      if (q.size() > 0 && !started) begin
        start_c   = (q[0].hs + 1 > engine_free) ? q[0].hs + 1 : engine_free;
        pg        = q[0].addr[15:6];
        exp_valid = start_c + ((pg == open_pg) ? 3 : 15) + 3;
        open_pg   = pg;
        baddr     = q[0].addr;
        beat      = 0;
        started   = 1;
      end
      occ = q.size() - ((started && start_c < cyc) ? 1 : 0);
      chk("arready", arready, occ < 4);
      exp_rv = started && (cyc >= exp_valid);
      chk("rvalid", rvalid, exp_rv);
      chk("mem_en", mem_en, started && (cyc == exp_valid - 1));
      if (mem_en && started) chk("mem_addr", mem_addr, baddr);
      if (exp_rv && rvalid) begin
        chk("rid", rid, q[0].id);
        chk("rdata", rdata, memfn(baddr));
        chk("rlast", rlast, beat == int'(q[0].len));
        chk("rresp", rresp, 2'b00);
        if (rready) begin
          if (beat == int'(q[0].len)) begin
            void'(q.pop_front());
            started     = 0;
            engine_free = cyc + 1;
          end else begin
            beat++;
            baddr     = baddr + 16'd4;
            exp_valid = cyc + 2;
          end
        end
      end
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [15:0] addr,
                         input logic [7:0] len, output int hs);
    int n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (arready !== 1'b1) begin
      chk("ar_timeout", 0, 1);
      hs = -1;
      return;
    end
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    hs = cyc;
    @(posedge clk);
    q.push_back('{id: id, addr: addr, len: len, hs: hs});
    #1 arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int c);
    int n = 0;
    @(negedge clk);
    while (rvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rvalid_timeout", rvalid, 1'b1);
    c = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arready"}, arready, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
    chk({tag, "_rid"}, rid, 4'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 16'd0);
  endtask

  int hs, c;

  initial begin
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #2 rst_n = 1'b1;
    rel_cyc = cyc; engine_free = cyc + 1;

    // 1: hot single beat
    rmode = 0;
    send_ar(4'd3, 16'h0010, 8'd0, hs);
    wait_rvalid(c);
    chk("t1_latency", 64'(c - hs), 64'd7);
    chk("t1_rid", rid, 4'd3);
    chk("t1_rlast", rlast, 1'b1);
    drain();

    // 2: cold 4-beat burst
    send_ar(4'd7, 16'h0400, 8'd3, hs);
    wait_rvalid(c);
    chk("t2_latency", 64'(c - hs), 64'd19);
    drain();

    // 3: back to back, second burst on the now-open page
    send_ar(4'd1, 16'h0800, 8'd0, hs);
    send_ar(4'd2, 16'h0820, 8'd1, hs);
    drain();

    // 4: six requests while R is stalled
    rmode = 3;
    fork
      begin
        int h;
        for (int i = 0; i < 6; i++) send_ar(4'(i + 8), 16'h0400 + 16'(i * 32), 8'd1, h);
      end
      begin
        repeat (40) @(posedge clk);
        rmode = 1;
      end
    join
    drain();

    // 5: long stall in BEAT and address wrap
    rmode = 3;
    send_ar(4'd5, 16'hFFFC, 8'd1, hs);
    repeat (30) @(negedge clk);
    rmode = 0;
    drain();

    // Random traffic
    rmode = 1;
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 3) * 320 + $urandom_range(0, 15) * 4);
      if (i == 10) a = 16'hFFF8;
      send_ar(4'($urandom_range(0, 15)), a, 8'($urandom_range(0, 3)), hs);
    end
    drain();

    // 6: asynchronous reset mid-burst
    rmode = 3;
    send_ar(4'd9, 16'h0840, 8'd2, hs);
    wait_rvalid(c);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rvalid", rvalid, 1'b0);
    q.delete(); started = 0; open_pg = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("t6");
    #2 rst_n = 1'b1;
    rel_cyc = cyc; engine_free = cyc + 1;
    rmode = 0;
    send_ar(4'd6, 16'h0020, 8'd0, hs);
    wait_rvalid(c);
    chk("t6_hot_latency", 64'(c - hs), 64'd7);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
